// File: rtl/enc_channel_pkg.sv
// Shared constants and field helpers for the quadrature encoder channel.
// Period fields are {dir, sat, count}; the count saturates at CNT_MAX.
package enc_channel_pkg;

    localparam logic [23:0] ENC_MIDRANGE = 24'h800000;
    localparam int          CNT_W        = 30;

    localparam int FLD_DIR     = 31;
    localparam int FLD_SAT     = 30;
    localparam int FLD_CNT_MSB = 29;

    typedef logic [CNT_W-1:0] perd_cnt_t;

    localparam perd_cnt_t CNT_MAX = '1;

    function automatic perd_cnt_t sat_inc(input perd_cnt_t v);
        return (v == CNT_MAX) ? v : v + perd_cnt_t'(1);
    endfunction

    function automatic logic [31:0] pack_fld(input logic dir, input logic sat, input perd_cnt_t cnt);
        logic [31:0] f;
        f                  = '0;
        f[FLD_DIR]         = dir;
        f[FLD_SAT]         = sat;
        f[FLD_CNT_MSB:0]   = cnt;
        return f;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer plus stability counter; output follows input after 2 + 2**DEB_BITS clocks.
// No flow control: free-running per clock.
module enc_debounce #(
    parameter int DEB_BITS = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    logic                sync1;
    logic                sync2;
    logic [DEB_BITS-1:0] cnt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the filtered level restarts the stability window.
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (&cnt) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + DEB_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/enc_channel.sv
// Quadrature encoder channel: debounced A/B, 24-bit position with sticky wrap flag, edge-period history.
// Count/dir update one clock after a filtered edge; period outputs one clock later. No backpressure.
module enc_channel
    import enc_channel_pkg::*;
#(
    parameter int DEB_BITS = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        set_enc,
    input  logic [23:0] preload,
    output logic        a_filt,
    output logic        b_filt,
    output logic [24:0] quad_data,
    output logic        dir,
    output logic [31:0] perd_data,
    output logic [31:0] qtr1_data,
    output logic [31:0] qtr5_data,
    output logic [31:0] run_data
);

    logic        a_prev;
    logic        b_prev;
    logic [23:0] count;
    logic        ovf;

    perd_cnt_t   run;
    perd_cnt_t   q1, q2, q3, q4, q5;

    logic        edge_a;
    logic        edge_b;
    logic        edge_ok;
    logic        dir_new;
    logic        reversal;

    logic [CNT_W+1:0] perd_sum;
    logic             perd_sat;
    perd_cnt_t        perd_cnt;

    enc_debounce #(.DEB_BITS(DEB_BITS)) u_deb_a (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (enc_a),
        .filt   (a_filt)
    );

    enc_debounce #(.DEB_BITS(DEB_BITS)) u_deb_b (
        .sysclk (sysclk),
        .reset  (reset),
        .raw    (enc_b),
        .filt   (b_filt)
    );

    // Simultaneous A and B changes carry no direction information and are discarded,
    // as is any edge coinciding with a preload.
    always_comb begin
        edge_a   = a_filt ^ a_prev;
        edge_b   = b_filt ^ b_prev;
        edge_ok  = (edge_a ^ edge_b) & ~set_enc;
        dir_new  = a_filt ^ b_prev;
        reversal = edge_ok & (dir_new != dir);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            a_prev <= 1'b0;
            b_prev <= 1'b0;
            count  <= ENC_MIDRANGE;
            ovf    <= 1'b0;
            dir    <= 1'b0;
        end else begin
            a_prev <= a_filt;
            b_prev <= b_filt;
            if (set_enc) begin
                count <= preload;
                ovf   <= 1'b0;
            end else if (edge_ok) begin
                dir <= dir_new;
                if (dir_new) begin
                    count <= count + 24'd1;
                    if (&count) ovf <= 1'b1;
                end else begin
                    count <= count - 24'd1;
                    if (count == 24'd0) ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            run <= '0;
            q1  <= CNT_MAX;
            q2  <= CNT_MAX;
            q3  <= CNT_MAX;
            q4  <= CNT_MAX;
            q5  <= CNT_MAX;
        end else if (edge_ok) begin
            run <= '0;
            q1  <= sat_inc(run);
            // Intervals measured before a reversal do not describe the new motion.
            if (reversal) begin
                q2 <= CNT_MAX;
                q3 <= CNT_MAX;
                q4 <= CNT_MAX;
                q5 <= CNT_MAX;
            end else begin
                q2 <= q1;
                q3 <= q2;
                q4 <= q3;
                q5 <= q4;
            end
        end else begin
            run <= sat_inc(run);
        end
    end

    always_comb begin
        perd_sum = {2'b00, q1} + {2'b00, q2} + {2'b00, q3} + {2'b00, q4};
        perd_sat = (q1 == CNT_MAX) || (q2 == CNT_MAX) || (q3 == CNT_MAX) || (q4 == CNT_MAX)
                   || (perd_sum > {2'b00, CNT_MAX});
        perd_cnt = perd_sat ? CNT_MAX : perd_sum[CNT_W-1:0];
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            perd_data <= pack_fld(1'b0, 1'b1, CNT_MAX);
            qtr1_data <= pack_fld(1'b0, 1'b1, CNT_MAX);
            qtr5_data <= pack_fld(1'b0, 1'b1, CNT_MAX);
        end else begin
            perd_data <= pack_fld(dir, perd_sat, perd_cnt);
            qtr1_data <= pack_fld(dir, q1 == CNT_MAX, q1);
            qtr5_data <= pack_fld(dir, q5 == CNT_MAX, q5);
        end
    end

    assign quad_data = {ovf, count};
    assign run_data  = pack_fld(dir, run == CNT_MAX, run);

endmodule

// File: tb/tb_enc_channel.sv
// Directed bench for enc_channel: reset state, debounce timing, counting, period history, wrap, async reset.
module tb_enc_channel;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        enc_a;
    logic        enc_b;
    logic        set_enc;
    logic [23:0] preload;
    logic        a_filt;
    logic        b_filt;
    logic [24:0] quad_data;
    logic        dir;
    logic [31:0] perd_data;
    logic [31:0] qtr1_data;
    logic [31:0] qtr5_data;
    logic [31:0] run_data;

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    enc_channel #(.DEB_BITS(2)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .set_enc   (set_enc),
        .preload   (preload),
        .a_filt    (a_filt),
        .b_filt    (b_filt),
        .quad_data (quad_data),
        .dir       (dir),
        .perd_data (perd_data),
        .qtr1_data (qtr1_data),
        .qtr5_data (qtr5_data),
        .run_data  (run_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic step(input logic a, input logic b);
        enc_a = a;
        enc_b = b;
        tick(100);
    endtask

    task automatic pulse_set(input logic [23:0] val);
        preload = val;
        set_enc = 1'b1;
        tick(1);
        set_enc = 1'b0;
        tick(2);
    endtask

    initial begin
        reset   = 1'b1;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        set_enc = 1'b0;
        preload = 24'h0;
        tick(2);
        reset = 1'b0;

        chk("rst_quad",  32'(quad_data), 32'h0800000);
        chk("rst_perd",  perd_data, 32'h7FFFFFFF);
        chk("rst_qtr1",  qtr1_data, 32'h7FFFFFFF);
        chk("rst_qtr5",  qtr5_data, 32'h7FFFFFFF);
        chk("rst_afilt", 32'(a_filt), 32'h0);
        chk("rst_bfilt", 32'(b_filt), 32'h0);
        chk("rst_dir",   32'(dir), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("idle_run", run_data, 32'(i));
            tick(1);
        end

        // Single-clock glitch must not reach the filtered output.
        enc_a = 1'b1;
        tick(1);
        enc_a = 1'b0;
        tick(10);
        chk("glitch_afilt", 32'(a_filt), 32'h0);
        chk("glitch_quad",  32'(quad_data), 32'h0800000);

        // First forward step doubles as the debounce latency check.
        enc_a = 1'b1;
        tick(5);
        chk("deb_before", 32'(a_filt), 32'h0);
        tick(1);
        chk("deb_after",  32'(a_filt), 32'h1);
        tick(94);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("fwd4_quad", 32'(quad_data), 32'h0800004);
        chk("fwd4_dir",  32'(dir), 32'h1);

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("fwd8_quad", 32'(quad_data), 32'h0800008);
        chk("fwd8_qtr1", qtr1_data, 32'h80000064);
        chk("fwd8_qtr5", qtr5_data, 32'h80000064);
        chk("fwd8_perd", perd_data, 32'h80000190);

        // Reversal: history beyond the newest quarter is invalidated.
        step(1'b0, 1'b1);
        chk("rev_quad", 32'(quad_data), 32'h0800007);
        chk("rev_dir",  32'(dir), 32'h0);
        chk("rev_qtr1", qtr1_data, 32'h00000064);
        chk("rev_qtr5", qtr5_data, 32'h7FFFFFFF);
        chk("rev_perd", perd_data, 32'h7FFFFFFF);

        pulse_set(24'h000000);
        chk("pre0_quad", 32'(quad_data), 32'h0000000);
        step(1'b1, 1'b1);
        chk("wrap_quad", 32'(quad_data), 32'h1FFFFFF);
        chk("wrap_dir",  32'(dir), 32'h0);
        pulse_set(24'h123456);
        chk("pre_quad",  32'(quad_data), 32'h0123456);

        // Asynchronous reset asserted between clock edges with live state.
        enc_a = 1'b0;
        tick(20);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_quad",  32'(quad_data), 32'h0800000);
        chk("arst_perd",  perd_data, 32'h7FFFFFFF);
        chk("arst_qtr1",  qtr1_data, 32'h7FFFFFFF);
        chk("arst_qtr5",  qtr5_data, 32'h7FFFFFFF);
        chk("arst_run",   run_data, 32'h0);
        chk("arst_afilt", 32'(a_filt), 32'h0);
        chk("arst_bfilt", 32'(b_filt), 32'h0);
        chk("arst_dir",   32'(dir), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
